// File: rtl/sn54170_pkg.sv
// Shared types and defaults for the SN54170 register-file sequencer.
// Requester ids double as the round-robin pointer encoding.
package sn54170_pkg;

   localparam int unsigned DefDataW = 4;
   localparam int unsigned DefAddrW = 2;

   typedef enum logic [2:0] {
      StIdle,
      StWrSetup,
      StWrPulse,
      StWrHold,
      StRdAddr,
      StDone
   } state_e;

   typedef enum logic {
      ReqA = 1'b0,
      ReqB = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the side not granted last.
module rr_arbiter2
   import sn54170_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_take,
   output logic [1:0] grant
);

   req_id_e last_q;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = (last_q == ReqB) ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= ReqB;
      end else if (grant_take && (grant != 2'b00)) begin
         last_q <= grant[1] ? ReqB : ReqA;
      end
   end

endmodule

// File: rtl/sn54170_ctrl.sv
// Sequencer/arbiter in front of the SN54170 4x4 register file. Every rf_* control
// line comes straight from a flop so the transparent write latch never sees glitches.
module sn54170_ctrl
   import sn54170_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [DATA_W-1:0] rf_data_in,
   output logic              rf_wr_enb,
   output logic [ADDR_W-1:0] rf_wr_sel,
   output logic              rf_rd_enb,
   output logic [ADDR_W-1:0] rf_rd_sel,
   input  logic [DATA_W-1:0] rf_data_out,
   output logic              busy
);

   state_e              state_q, state_d;
   req_id_e             id_q, id_d;
   logic                wr_enb_q, wr_enb_d;
   logic                rd_enb_q, rd_enb_d;
   logic [ADDR_W-1:0]   wr_sel_q, wr_sel_d;
   logic [ADDR_W-1:0]   rd_sel_q, rd_sel_d;
   logic [DATA_W-1:0]   data_in_q, data_in_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                busy_q;

   logic [1:0]          grant;
   logic                grant_take;
   logic                win_we;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;

   rr_arbiter2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        ({b_req, a_req}),
      .grant_take (grant_take),
      .grant      (grant)
   );

   assign win_we    = grant[1] ? b_we    : a_we;
   assign win_addr  = grant[1] ? b_addr  : a_addr;
   assign win_wdata = grant[1] ? b_wdata : a_wdata;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      wr_enb_d   = 1'b1;
      rd_enb_d   = 1'b1;
      wr_sel_d   = wr_sel_q;
      rd_sel_d   = rd_sel_q;
      data_in_d  = data_in_q;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      grant_take = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (grant != 2'b00) begin
               grant_take = 1'b1;
               id_d       = grant[1] ? ReqB : ReqA;
               if (win_we) begin
                  // Write sel/data only move here, so they are stable across the pulse.
                  state_d   = StWrSetup;
                  wr_sel_d  = win_addr;
                  data_in_d = win_wdata;
               end else begin
                  state_d  = StRdAddr;
                  rd_sel_d = win_addr;
                  rd_enb_d = 1'b0;
               end
            end
         end
         StWrSetup: begin
            state_d  = StWrPulse;
            wr_enb_d = 1'b0;
         end
         StWrPulse: begin
            state_d = StWrHold;
         end
         StWrHold: begin
            state_d = StDone;
            a_ack_d = (id_q == ReqA);
            b_ack_d = (id_q == ReqB);
         end
         StRdAddr: begin
            state_d = StDone;
            a_ack_d = (id_q == ReqA);
            b_ack_d = (id_q == ReqB);
            if (id_q == ReqA) begin
               a_rdata_d = rf_data_out;
            end else begin
               b_rdata_d = rf_data_out;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         id_q      <= ReqA;
         wr_enb_q  <= 1'b1;
         rd_enb_q  <= 1'b1;
         wr_sel_q  <= '0;
         rd_sel_q  <= '0;
         data_in_q <= '0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         wr_enb_q  <= wr_enb_d;
         rd_enb_q  <= rd_enb_d;
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         data_in_q <= data_in_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         busy_q    <= (state_d != StIdle);
      end
   end

   assign rf_wr_enb  = wr_enb_q;
   assign rf_rd_enb  = rd_enb_q;
   assign rf_wr_sel  = wr_sel_q;
   assign rf_rd_sel  = rd_sel_q;
   assign rf_data_in = data_in_q;
   assign a_ack      = a_ack_q;
   assign b_ack      = b_ack_q;
   assign a_rdata    = a_rdata_q;
   assign b_rdata    = b_rdata_q;
   assign busy       = busy_q;

endmodule

// File: doc/sn54170_ctrl.md
# sn54170_ctrl

Sequencer and two-port round-robin arbiter for the 4-word × 4-bit SN54170 register file. It sits between two synchronous requesters (A, B) and the register file's level-sensitive write/read controls. It turns single-cycle-clean transaction handshakes into glitch-free setup/pulse/hold write sequences and gated reads. Every register-file control line is driven from a flop, never from combinational logic, because the file's write latch is transparent while `wr_enb` is low.

## Interface
- `DATA_W`, default 4: word width; must match the register file.
- `ADDR_W`, default 2: select width; must match the register file (4 words).

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_req` in 1: requester A transaction request; held high with fields stable until `a_ack`.
- `a_we` in 1: 1 = write, 0 = read.
- `a_addr` in ADDR_W: word select.
- `a_wdata` in DATA_W: write data.
- `a_ack` out 1: one-cycle completion pulse.
- `a_rdata` out DATA_W: last read result for A; held until A's next read ack.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as the A ports, for requester B.
- `rf_data_in` out DATA_W: to register file `data_in`.
- `rf_wr_enb` out 1: to `wr_enb`, active-low.
- `rf_wr_sel` out ADDR_W: to `wr_sel`.
- `rf_rd_enb` out 1: to `rd_enb`, active-low; high forces file output to all-ones.
- `rf_rd_sel` out ADDR_W: to `rd_sel`.
- `rf_data_out` in DATA_W: from register file `data_out`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, DONE.
- IDLE:
  - If any req is high, pick a winner and latch its we/addr/wdata and id.
  - Go to WR_SETUP if we = 1, else RD_ADDR.
- Write path, one cycle per state:
  - WR_SETUP: sel and data driven, `rf_wr_enb` = 1.
  - WR_PULSE: `rf_wr_enb` = 0.
  - WR_HOLD: `rf_wr_enb` = 1; sel and data still held.
  - Then go to DONE.
- Read path:
  - RD_ADDR: `rf_rd_sel` driven, `rf_rd_enb` = 0.
  - On the edge leaving RD_ADDR, capture `rf_data_out` into the winner's rdata register, then go to DONE.
- DONE:
  - Winner's ack is high for exactly this cycle.
  - All req inputs are ignored in this state.
  - Always return to IDLE.
- `rf_rd_enb` returns to 1 in every state except RD_ADDR.
- `rf_wr_sel` and `rf_data_in` change only on entry to WR_SETUP, so they are stable throughout the low write pulse.
- Arbitration:
  - Two-way round-robin with a last-grant pointer.
  - A lone request wins.
  - On a tie, the requester not granted last wins.
  - The pointer updates on every grant.
- Non-winning requests stay pending; no request is dropped or starved.

## Timing
- Reset values:
  - State IDLE, `busy` = 0.
  - `rf_wr_enb` = 1, `rf_rd_enb` = 1.
  - `rf_wr_sel`, `rf_rd_sel`, `rf_data_in` = 0.
  - `a_ack`, `b_ack` = 0; `a_rdata`, `b_rdata` = 0.
  - Last-grant pointer = B, so A wins the first tie.
- Let E0 be the edge at which IDLE samples a req.
  - Write: ack is high in the cycle after E3.
  - Read: ack is high in the cycle after E1; rdata is valid in that same cycle.
- Requester rule: at the edge ending its ack cycle, the requester either drops req or presents the next transaction. IDLE samples it one cycle later.
  - Minimum spacing is 5 cycles per write and 3 cycles per read.
- Loser latency: bounded by one full winner transaction plus one IDLE cycle.
- Write-then-read to the same address, from either requester, returns the new value.
- `rst` asserted mid-transaction:
  - The next edge forces IDLE and releases `rf_wr_enb`/`rf_rd_enb` high.
  - No ack is issued.
  - The target word is undefined if reset lands in WR_PULSE or WR_HOLD.
  - rdata registers clear.
- `busy` is registered and matches `state != IDLE`.

## Structure
- `sn54170_pkg`: state enum, `DATA_W`/`ADDR_W` defaults, requester-id type (A = 0, B = 1).
- Sub-module `rr_arbiter2`: two requests in, one-hot grant out, pointer update on `grant_take`, synchronous reset to pointer = B.
- `sn54170_ctrl` owns the FSM, transaction latch, output flops and rdata registers. The bench instantiates the existing register-file model beside it.

## Test plan
- Reset then idle: all outputs at reset values, `rf_wr_enb` = `rf_rd_enb` = 1 for 10 cycles.
- A writes 0xA to addr 2, then A reads addr 2 → `rf_wr_enb` low for exactly one cycle with sel = 2 and data = 0xA stable in the cycles before and after; the read ack arrives with `a_rdata` = 0xA.
- A and B raise req in the same cycle after reset (A writes 0x5 @1, B reads @1) → A granted first; B's read returns 0x5; next tie goes to A only if B was last.
- Both hold continuous writes (A: 0x3 @0, B: 0xC @3) for 8 transactions → acks strictly alternate A, B, A, …; final contents are 0x3 @0 and 0xC @3.
- `rst` pulsed during WR_PULSE → `rf_wr_enb` = 1 on the next edge, no ack, state IDLE; a subsequent normal transaction completes correctly.
- B reads all four addresses after A writes 1, 2, 4, 8 → `b_rdata` sequence is 1, 2, 4, 8; it never shows 0xF, since a read must never sample while `rf_rd_enb` is high.
